// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative scheduler: FSM states, round
// constants, S-box lookup, xtime and one key-schedule step.
package aes_pkg;

  localparam int NROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // Indexed by round number 1..10; unused slots are zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the slice base is (255 - b) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] keyexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round) and AddRoundKey. Byte i of the state lives in [127-8i -: 8].
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;

  genvar gi;

  // Byte index is row + 4*column; row r rotates left by r columns.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign sb[gi] = sbox(state_in[127-8*gi -: 8]);
      assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
      assign sr_flat[127-8*gi -: 8] = sr[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[4*gi];
      assign a1 = sr[4*gi+1];
      assign a2 = sr[4*gi+2];
      assign a3 = sr[4*gi+3];
      assign mc_flat[127-32*gi -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
  endgenerate

  assign state_out = (final_round ? sr_flat : mc_flat) ^ round_key;

endmodule

// File: rtl/aes_iter_sched.sv
// Two-requester round-robin AES-128 encryption scheduler over one shared round unit.
// Optional completed-block counter port blk_count enabled by AES_SCHED_STATS_EN.
module aes_iter_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_plaintext,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_plaintext,
  input  logic [127:0] req1_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_id,
  output logic         busy
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  sched_state_t state_reg;
  sched_state_t state_next;
  logic [127:0] data_reg;
  logic [127:0] rkey_reg;
  logic [3:0]   rnd_reg;
  logic         id_reg;
  logic         rr_reg;

  logic         grant_id;
  logic         accept;
  logic         last_round;
  logic [127:0] sel_pt;
  logic [127:0] sel_key;
  logic [127:0] round_key_next;
  logic [127:0] round_out;

  // A lone requester wins outright; on contention the pointer decides.
  assign grant_id   = (req0_valid && req1_valid) ? rr_reg : req1_valid;
  assign accept     = (state_reg == IDLE) && (req0_valid || req1_valid);
  assign last_round = (rnd_reg == 4'(NROUNDS));
  assign sel_pt     = grant_id ? req1_plaintext : req0_plaintext;
  assign sel_key    = grant_id ? req1_key : req0_key;

  assign round_key_next = keyexp(rkey_reg, RCON[rnd_reg]);

  aes_round_comb u_round (
    .state_in    (data_reg),
    .round_key   (round_key_next),
    .final_round (last_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ROUND;
      ROUND:   if (last_round) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = req0_valid && !grant_id;
        req1_ready = req1_valid && grant_id;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = data_reg;
  assign out_id   = id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      rkey_reg <= '0;
      rnd_reg  <= '0;
      id_reg   <= 1'b0;
      rr_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg <= sel_pt ^ sel_key;
            rkey_reg <= sel_key;
            rnd_reg  <= 4'd1;
            id_reg   <= grant_id;
            rr_reg   <= ~grant_id;
          end
        end
        ROUND: begin
          data_reg <= round_out;
          rkey_reg <= round_key_next;
          rnd_reg  <= rnd_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_SCHED_STATS_EN
  logic [31:0] blk_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      blk_count_reg <= blk_count_reg + 32'd1;
    end
  end

  assign blk_count = blk_count_reg;
`endif

endmodule

// File: doc/aes_iter_sched.md
# aes_iter_sched

Iterative AES-128 encryption scheduler that shares one combinational round unit and one on-the-fly key-expansion step between two requesters. It arbitrates round-robin and latches the winner's plaintext and key. It then steps the shared round datapath through the initial AddRoundKey and 10 rounds, and presents the ciphertext on a valid/ready output tagged with the requester id. It replaces the fully unrolled ten-round pipeline where area matters more than throughput.

## Interface
- NROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle
- req0_plaintext  in  128  requester 0 plaintext, byte 0 in [127:120]
- req0_key  in  128  requester 0 cipher key
- req1_valid / req1_ready / req1_plaintext / req1_key  as requester 0, widths 1/1/128/128
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- out_id  out  1  requester that owns out_data
- busy  out  1  high in any state other than IDLE
- blk_count  out  32  completed-block counter; present only with AES_SCHED_STATS_EN

## Operation
- States are IDLE, ROUND and DONE.
- **IDLE:**
  - Grant selection: if exactly one reqN_valid is high, grant it. If both are high, grant the requester selected by pointer rr (0 selects req0).
  - reqN_ready is high only in IDLE, only for the granted requester, and only while its valid is high.
  - On handshake: state_q <= plaintext ^ key; rkey_q <= key; rnd_q <= 1; id_q <= granted; rr <= ~granted; go to ROUND.
- **ROUND:** every cycle:
  - nk = keyexp(rkey_q, rcon[rnd_q]).
  - state_q <= round(state_q, nk, final = (rnd_q == NROUNDS)); the final round skips MixColumns.
  - rkey_q <= nk; rnd_q <= rnd_q + 1 (4-bit counter).
  - After the update with rnd_q == NROUNDS, go to DONE.
- **DONE:**
  - out_valid = 1; out_data = state_q; out_id = id_q.
  - Outputs hold until out_ready. On the out handshake go to IDLE.
- Requesters hold valid and data stable until ready. The scheduler never samples input data outside the handshake cycle.
- A requester that is not granted simply waits; no request is dropped.
- rr changes only on a grant.
- Reset mid-operation: the in-flight block is discarded and all state returns to reset values. No output handshake occurs for that block.

## Timing
- Reset values: out_valid 0, out_data 0, out_id 0, busy 0, req0_ready 0, req1_ready 0, rr 0, state IDLE, blk_count 0.
- Latency: input handshake at edge E puts out_valid high after edge E+10.
- Earliest next acceptance is one cycle after the out handshake.
- Throughput with out_ready tied high is one block per 12 cycles: 1 IDLE, 10 ROUND, 1 DONE.
- req*_ready is combinational from state, rr and req*_valid. No path exists from out_ready to req*_ready.
- out_valid is registered and stays high until the handshake, regardless of inputs.

## Configuration
- Macro AES_SCHED_STATS_EN.
- **Defined:**
  - blk_count port exists and increments by 1 on each out handshake.
  - It wraps from 32'hFFFFFFFF to 0 and resets to 0.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- Package aes_pkg contains:
  - NROUNDS;
  - the state enum {IDLE, ROUND, DONE};
  - the rcon table;
  - the sbox function;
  - keyexp function (one AES-128 key-schedule step).
- Sub-module aes_round_comb holds the combinational round: inputs are state, round key and final flag; it performs SubBytes, ShiftRows, MixColumns unless final, then AddRoundKey.
- The scheduler holds the FSM, the arbiter, the registers and the optional counter.

## Test plan
- FIPS-197 C.1 on req0: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Expect out_data 69c4e0d86a7b0430d8cdb78070b4c55a and out_id 0.
  - out_valid rises exactly 10 edges after the handshake.
- FIPS-197 B on req1: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Expect 3925841d02dc09fbdc118597196a0b32 and out_id 1.
- Both valid from reset, continuous traffic, out_ready=1:
  - Grants alternate 0,1,0,1.
  - Requester 1 (all-zero pt and key) yields 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Accepts are spaced 12 cycles apart.
- Backpressure: out_ready held 0 for 20 cycles in DONE.
  - out_valid and out_data stay stable.
  - Both req*_ready stay 0.
  - Accepting resumes one cycle after out_ready rises.
- Assert rst_n low at round 5, release, resubmit C.1.
  - No out_valid for the aborted block.
  - The correct result follows; rr is back at 0.
- With AES_SCHED_STATS_EN, run 3 blocks: blk_count reads 3. Preload the counter via force to FFFFFFFF, run one more block: it wraps to 0.
